// File: rtl/fusion_frame_sequencer_if.sv
// Handshake and bus bundle between the fusion frame sequencer and its
// environment (frame-buffer controller, fusion datapath, fused store).
//   master : sequencer side (drives strobes, addresses and status)
//   slave  : environment side (drives start, num_images, frame_avail)
// Signals:
//   start, num_images, frame_avail          environment -> sequencer
//   frame_ack, rd_en, rd_addr, img_idx,
//   first_frame, wr_en, wr_addr,
//   frame_done, busy, done                  sequencer -> environment
//   stall_cycles                            only when FUSE_SEQ_STATS_EN is defined
interface fusion_frame_sequencer_if #(
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned ADDR_W = 19
);
    logic              start;
    logic [IDX_W-1:0]  num_images;
    logic              frame_avail;
    logic              frame_ack;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [IDX_W-1:0]  img_idx;
    logic              first_frame;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              frame_done;
    logic              busy;
    logic              done;
`ifdef FUSE_SEQ_STATS_EN
    logic [31:0]       stall_cycles;

    modport master (
        input  start, num_images, frame_avail,
        output frame_ack, rd_en, rd_addr, img_idx, first_frame,
               wr_en, wr_addr, frame_done, busy, done, stall_cycles
    );

    modport slave (
        output start, num_images, frame_avail,
        input  frame_ack, rd_en, rd_addr, img_idx, first_frame,
               wr_en, wr_addr, frame_done, busy, done, stall_cycles
    );
`else
    modport master (
        input  start, num_images, frame_avail,
        output frame_ack, rd_en, rd_addr, img_idx, first_frame,
               wr_en, wr_addr, frame_done, busy, done
    );

    modport slave (
        output start, num_images, frame_avail,
        input  frame_ack, rd_en, rd_addr, img_idx, first_frame,
               wr_en, wr_addr, frame_done, busy, done
    );
`endif
endinterface

// File: rtl/fusion_frame_sequencer.sv
// Sequences the streaming fusion datapath over a burst of input frames.
// Issues N = IM_LEN*IM_WID pixel reads per frame, re-times them into
// fused-store writes through a PIPE_LAT-deep delay line, and steps the
// frame index until the latched frame count has been fused.
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  fusion_frame_sequencer_if.master (start/num_images/frame_avail in;
//        frame_ack, rd_en/rd_addr, img_idx, first_frame, wr_en/wr_addr,
//        frame_done, busy, done out; all outputs registered)
// Optional feature macro: FUSE_SEQ_STATS_EN adds bus.stall_cycles, a
// saturating count of cycles spent waiting for input frames in a burst.
module fusion_frame_sequencer #(
    parameter int unsigned IM_LEN            = 520,
    parameter int unsigned IM_WID            = 520,
    parameter int unsigned LOG2_NO_OF_IMAGES = 4,
    parameter int unsigned PIPE_LAT          = 21,
    parameter int unsigned ADDR_W            = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    fusion_frame_sequencer_if.master bus
);

    localparam int unsigned IDX_W     = LOG2_NO_OF_IMAGES + 1;
    localparam int unsigned N_PIX     = IM_LEN * IM_WID;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  img_idx_q, img_idx_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              first_frame_q, first_frame_d;
    logic              frame_ack_q, frame_ack_d;
    logic              rd_en_q, rd_en_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PIPE_LAT-1:0] wr_pipe_q;
    logic              wr_en_w;

    assign wr_en_w = wr_pipe_q[PIPE_LAT-1];

    // Next-state and next-output decode
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        img_idx_d     = img_idx_q;
        first_frame_d = first_frame_q;
        rd_cnt_d      = rd_cnt_q;
        frame_ack_d   = 1'b0;
        rd_en_d       = 1'b0;
        rd_addr_d     = '0;
        frame_done_d  = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // A zero frame count is treated as a single frame
                    count_d       = (bus.num_images == '0) ? IDX_W'(1) : bus.num_images;
                    img_idx_d     = '0;
                    first_frame_d = 1'b1;
                    rd_cnt_d      = '0;
                    state_d       = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (bus.frame_avail) begin
                    frame_ack_d = 1'b1;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                // Datapath cannot stall: one read per cycle for the whole frame
                rd_en_d   = 1'b1;
                rd_addr_d = rd_cnt_q;
                if (rd_cnt_q == LAST_ADDR) begin
                    rd_cnt_d = '0;
                    state_d  = DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Next frame's reads wait until this frame's last write lands
                if (wr_en_w && (wr_addr_q == LAST_ADDR)) begin
                    frame_done_d = 1'b1;
                    if (img_idx_q == count_q - IDX_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        img_idx_d     = img_idx_q + IDX_W'(1);
                        first_frame_d = 1'b0;
                        state_d       = WAIT_FRAME;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered from the next state so busy drops together with done
        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            img_idx_q     <= '0;
            first_frame_q <= 1'b0;
            rd_cnt_q      <= '0;
            rd_addr_q     <= '0;
            frame_ack_q   <= 1'b0;
            rd_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            img_idx_q     <= img_idx_d;
            first_frame_q <= first_frame_d;
            rd_cnt_q      <= rd_cnt_d;
            rd_addr_q     <= rd_addr_d;
            frame_ack_q   <= frame_ack_d;
            rd_en_q       <= rd_en_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Write-back alignment: rd_en delayed by PIPE_LAT, wr_addr tracks writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pipe_q <= '0;
            wr_addr_q <= '0;
        end else begin
            wr_pipe_q <= (wr_pipe_q << 1) | PIPE_LAT'(rd_en_q);
            if (frame_ack_q) begin
                wr_addr_q <= '0;
            end else if (wr_en_w) begin
                wr_addr_q <= (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
            end
        end
    end

`ifdef FUSE_SEQ_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of WAIT_FRAME cycles, cleared by an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && bus.start) begin
            stall_q <= '0;
        end else if ((state_q == WAIT_FRAME) && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

    assign bus.frame_ack   = frame_ack_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.img_idx     = img_idx_q;
    assign bus.first_frame = first_frame_q;
    assign bus.wr_en       = wr_en_w;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_fusion_frame_sequencer.sv
// Self-checking bench for fusion_frame_sequencer (N=16, PIPE_LAT=3).
// Each burst is planned as a schedule of event times (frame accept, read
// window, write window, frame_done, done) from which every output is
// predicted for every cycle; random start/num_images noise while busy and
// random frame_avail outside wait windows must have no effect.
module tb_fusion_frame_sequencer;

    localparam int unsigned IM_LEN   = 4;
    localparam int unsigned IM_WID   = 4;
    localparam int unsigned LOG2     = 2;
    localparam int unsigned PIPE_LAT = 3;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned IDX_W    = LOG2 + 1;
    localparam int          N        = IM_LEN * IM_WID;
    localparam int          MAXF     = 8;

    typedef struct packed {
        logic              frame_ack;
        logic              rd_en;
        logic [ADDR_W-1:0] rd_addr;
        logic [IDX_W-1:0]  img_idx;
        logic              first_frame;
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic              frame_done;
        logic              busy;
        logic              done;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Current burst plan
    bit have_burst = 1'b0;
    int e0;
    int bm;
    int d_t;
    int w_t[MAXF];
    int a_t[MAXF];
    int f_t[MAXF];

    fusion_frame_sequencer_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

    fusion_frame_sequencer #(
        .IM_LEN(IM_LEN),
        .IM_WID(IM_WID),
        .LOG2_NO_OF_IMAGES(LOG2),
        .PIPE_LAT(PIPE_LAT),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected outputs in cycle c (the cycle following clock edge c)
    function automatic obs_t model(int c);
        obs_t e = '0;
        int idx = 0;
        if (!have_burst) return e;
        for (int k = 0; k < bm; k++) begin
            if (c == a_t[k]) e.frame_ack = 1'b1;
            if (c >= a_t[k] + 1 && c <= a_t[k] + N) begin
                e.rd_en   = 1'b1;
                e.rd_addr = ADDR_W'(c - a_t[k] - 1);
            end
            if (c >= a_t[k] + 1 + int'(PIPE_LAT) && c <= a_t[k] + N + int'(PIPE_LAT)) begin
                e.wr_en   = 1'b1;
                e.wr_addr = ADDR_W'(c - a_t[k] - 1 - int'(PIPE_LAT));
            end
            if (c == f_t[k]) e.frame_done = 1'b1;
            if (k < bm - 1 && c >= f_t[k]) idx++;
        end
        e.img_idx     = IDX_W'(idx);
        e.first_frame = (idx == 0);
        e.busy        = (c >= e0 && c < d_t);
        e.done        = (c == d_t);
        return e;
    endfunction

    // Cycles spent waiting for a frame, counted strictly before cycle c
    function automatic int stall_model(int c);
        int s = 0;
        if (!have_burst) return 0;
        for (int k = 0; k < bm; k++)
            for (int x = w_t[k]; x < a_t[k]; x++)
                if (x < c) s++;
        return s;
    endfunction

    // frame_avail for clock edge x: low through each wait window, high on
    // the planned accept edge, random where the sequencer ignores it
    function automatic logic avail_for(int x);
        if (have_burst)
            for (int k = 0; k < bm; k++)
                if (x > w_t[k] && x <= a_t[k]) return (x == a_t[k]);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag);
        obs_t obs;
        obs_t exp;
        obs.frame_ack   = bus.frame_ack;
        obs.rd_en       = bus.rd_en;
        obs.rd_addr     = bus.rd_addr;
        obs.img_idx     = bus.img_idx;
        obs.first_frame = bus.first_frame;
        obs.wr_en       = bus.wr_en;
        obs.wr_addr     = bus.wr_addr;
        obs.frame_done  = bus.frame_done;
        obs.busy        = bus.busy;
        obs.done        = bus.done;
        exp = model(cyc);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h (ack,rd_en,rd_addr,idx,first,wr_en,wr_addr,fdone,busy,done)",
                   tag, cyc, obs, exp);
        end
`ifdef FUSE_SEQ_STATS_EN
        vectors++;
        assert (bus.stall_cycles === 32'(stall_model(cyc))) else begin
            miscompares++;
            $error("FAIL %s_stall cyc=%0d observed=%0d expected=%0d",
                   tag, cyc, bus.stall_cycles, stall_model(cyc));
        end
`endif
    endtask

    // Drive inputs for the next edge, advance one clock and check outputs
    task automatic tick(input bit launch, input int nreq);
        int x;
        x = cyc + 1;
        if (launch) begin
            bus.start      = 1'b1;
            bus.num_images = IDX_W'(nreq);
        end else if (have_burst && x > e0 && x <= d_t) begin
            bus.start      = 1'($urandom_range(0, 1));
            bus.num_images = IDX_W'($urandom_range(0, 7));
        end else begin
            bus.start      = 1'b0;
            bus.num_images = IDX_W'($urandom_range(0, 7));
        end
        bus.frame_avail = avail_for(x);
        @(posedge clk);
        cyc++;
        #1;
        check("cycle");
    endtask

    // mode 0: no stalls; mode 1: 10-cycle stall before frame 1; else random
    task automatic run_burst(input int nreq, input int mode, input int rst_frame);
        int s;
        e0 = cyc + 1;
        bm = (nreq == 0) ? 1 : nreq;
        for (int k = 0; k < bm; k++) begin
            w_t[k] = (k == 0) ? e0 : f_t[k-1];
            if (mode == 0)      s = 0;
            else if (mode == 1) s = (k == 1) ? 10 : int'($urandom_range(0, 3));
            else                s = int'($urandom_range(0, 6));
            a_t[k] = w_t[k] + 1 + s;
            f_t[k] = a_t[k] + N + int'(PIPE_LAT) + 1;
        end
        d_t = f_t[bm-1] + 1;
        have_burst = 1'b1;
        tick(1'b1, nreq);
        while (cyc < d_t + 1) begin
            tick(1'b0, 0);
            if (rst_frame >= 0 && rst_frame < bm && cyc == a_t[rst_frame] + 8) begin
                // Abandon the burst while rd_addr 7 of this frame is out
                rst = 1'b1;
                have_burst = 1'b0;
                #1;
                check("reset_mid_burst");
                repeat (2) tick(1'b0, 0);
                rst = 1'b0;
                repeat (PIPE_LAT + 2) tick(1'b0, 0);
                return;
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.num_images  = '0;
        bus.frame_avail = 1'b0;
        repeat (2) tick(1'b0, 0);
        rst = 1'b0;
        repeat (2) tick(1'b0, 0);

        run_burst(1, 0, -1);            // single frame, source always ready
        repeat (2) tick(1'b0, 0);
        run_burst(3, 0, -1);            // burst of three
        run_burst(3, 1, -1);            // stalled source before frame 1
        run_burst(0, 2, -1);            // zero count behaves as one
        run_burst(4, 2, -1);            // maximum burst
        run_burst(3, 0, 1);             // reset during frame 1
        run_burst(2, 2, -1);            // full burst after reset
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) tick(1'b0, 0);
            run_burst(int'($urandom_range(0, 4)), 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
